ias_mem_ctrl: RTL
=================

# ias_mem_ctrl

Sequencing controller and two-port arbiter for the IAS machine's latch-based byte memory array. It shares one bank of byte memory cells between the instruction-fetch unit (port 0) and the operand/execute unit (port 1), using round-robin arbitration. For each granted access it generates the multi-cycle setup → set-strobe → hold sequence that the level-sensitive NAND latch cells require. It sits between the IAS control unit and the memory array, and is the only driver of the array's `set` lines.

## Interface
- `ADDR_W`, 4, address width; array depth is 2**ADDR_W rows.
- `DATA_W`, 8, data width per row (one byte memory cell).
- `clk  in  1`  single system clock; all state changes on rising edge.
- `rst  in  1`  synchronous, active-high reset.
- `req0/req1  in  1`  access request from port 0 / port 1; held high until that port's ack.
- `we0/we1  in  1`  1 = write, 0 = read; must be stable while req is high.
- `addr0/addr1  in  ADDR_W`  row address; must be stable while req is high.
- `wdata0/wdata1  in  DATA_W`  write data; must be stable while req is high.
- `ack0/ack1  out  1`  one-cycle completion pulse to the granted port.
- `rdata  out  DATA_W`  read data; valid in the ack cycle and held until the next read completes.
- `mem_wdata  out  DATA_W`  data bus to all array rows.
- `mem_set  out  2**ADDR_W`  one-hot set strobe, one bit per row.
- `mem_rdata  in  2**ADDR_W*DATA_W`  concatenated outputs of all rows; row i occupies bits [i*DATA_W +: DATA_W].
- `busy  out  1`  high in every state except IDLE.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, READ, DONE (plus VERIFY when configured).
- IDLE: if any req is high, grant one port.
  - Latch that port's we, addr and wdata into internal registers.
  - Go to SETUP on a write, READ on a read.
- Arbitration: round-robin with a `last` pointer.
  - If both ports request, grant the port that was not granted last.
  - If only one port requests, it wins.
  - `last` updates on each grant and resets to 1, so port 0 wins the first contention.
- SETUP: drive mem_wdata from the latched data; mem_set stays all zero.
- STROBE: mem_set[addr] = 1; all other bits stay 0.
- HOLD: mem_set returns to zero; mem_wdata is unchanged.
- READ: capture the addressed row of mem_rdata into rdata.
- DONE: pulse the granted port's ack; go to IDLE.
- A requester must deassert req at the edge where it samples ack.
  - A req still high in the following IDLE cycle is treated as a new request.
- No requests are accepted outside IDLE; the latched fields are immune to input changes during an access.
- Reset values:
  - FSM = IDLE; `last` = 1.
  - ack0, ack1, busy = 0.
  - mem_set = 0; mem_wdata = 0; rdata = 0.
  - err = 0 when present.
- Reset asserted mid-access: mem_set is forced to 0 on the next edge and the access is abandoned; no ack is issued. The row contents are whatever the latches last captured.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled high.
- Write latency, grant to ack: SETUP c1, STROBE c2, HOLD c3, DONE c4. Ack is high in c4.
- Read latency: READ c1, DONE c2. Ack and new rdata appear in c2.
- Back-to-back accesses: the next grant can occur at the earliest in the IDLE cycle after DONE. This gives a write throughput of one per 5 cycles and a read throughput of one per 3 cycles.
- mem_set is high for exactly one cycle per write, never in the same cycle that mem_wdata changes, and never during a read.
- All outputs are registered.

## Configuration
- `IAS_MEM_CTRL_VERIFY_EN`: write read-back check.
  - When defined:
    - After HOLD, the FSM enters VERIFY for 1 cycle and compares the addressed row of mem_rdata with the latched wdata.
    - On a mismatch, sticky output `err` is set to 1; only rst clears it.
    - Write latency becomes 5 cycles, with ack in c5.
  - When undefined: no VERIFY state, no err port, and write latency is 4 cycles.

## Structure
- Shared package `ias_mem_pkg` holds:
  - the FSM state enum;
  - the default ADDR_W and DATA_W constants;
  - the write and read latency constants, which the bench uses for checking.
- One sub-module, `ias_rr_arb2`: the 2-requester round-robin arbiter.
  - Inputs: req[1:0] and an update enable.
  - Outputs: one-hot grant[1:0].
  - Holds the `last` pointer.
- The controller FSM, the one-hot set decoder and the read mux stay in `ias_mem_ctrl`.

## Test plan
- Reset, then port 0 writes 8'hA5 to addr 3:
  - mem_set = 16'h0008 in c2 only;
  - ack0 in c4;
  - busy high c1–c4.
- After the write above, port 1 reads addr 3 with the array model returning 8'hA5: ack1 in c2, and rdata = 8'hA5 held until the next read.
- req0 and req1 high in the same cycle from reset:
  - port 0 is served first, then port 1;
  - with both still requesting, the grants alternate 0, 1, 0, 1.
- rst asserted in STROBE during a write to addr 7:
  - mem_set = 0 next cycle;
  - no ack;
  - FSM in IDLE.
- Port 1 changes addr and wdata mid-write: the array still receives the originally latched addr and data.
- With `IAS_MEM_CTRL_VERIFY_EN`, the array model corrupts bit 0 on a write of 8'h3C:
  - err = 1 from c4 onwards;
  - ack in c5;
  - err stays 1 until rst.

Source files
------------

// File: rtl/ias_mem_pkg.sv
// ias_mem_pkg: shared types and constants for the IAS memory controller.
// Build option IAS_MEM_CTRL_VERIFY_EN adds the write read-back state.
package ias_mem_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

`ifdef IAS_MEM_CTRL_VERIFY_EN
  localparam int WR_LAT = 5;
`else
  localparam int WR_LAT = 4;
`endif
  localparam int RD_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_READ   = 3'd4,
    S_DONE   = 3'd5
`ifdef IAS_MEM_CTRL_VERIFY_EN
    , S_VERIFY = 3'd6
`endif
  } state_e;

endpackage

// File: rtl/ias_mem_ctrl_if.sv
// ias_mem_ctrl_if: two-port requester bus of the IAS memory controller.
// master = control unit side, slave = controller side.
interface ias_mem_ctrl_if
  import ias_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata, busy
  );
endinterface

// File: rtl/ias_mem_ctrl_arb.sv
// ias_rr_arb2: two-requester round-robin arbiter.
// last points at the most recent winner; reset favours port 0.
module ias_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
  logic last_q;
  logic last_d;

  // One-hot grant; on contention the port not served last wins.
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    unique case (1'b1)
      (req_i[0] && (!req_i[1] || last_q)): gnt_o = 2'b01;
      (req_i[1] && (!req_i[0] || !last_q)): gnt_o = 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (en_i && (gnt_o != 2'b00))
      last_d = gnt_o[1];
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
endmodule

// File: rtl/ias_mem_ctrl.sv
// ias_mem_ctrl: arbiter + setup/strobe/hold sequencer for latch memory.
// Build option IAS_MEM_CTRL_VERIFY_EN adds VERIFY and the sticky err_o.
module ias_mem_ctrl
  import ias_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  ias_mem_ctrl_if.slave                   bus,
  output logic [DATA_W-1:0]               mem_wdata_o,
  output logic [(1<<ADDR_W)-1:0]          mem_set_o,
  input  logic [(1<<ADDR_W)*DATA_W-1:0]   mem_rdata_i
`ifdef IAS_MEM_CTRL_VERIFY_EN
  , output logic                          err_o
`endif
);
  localparam int DEPTH = 1 << ADDR_W;

  state_e            state_q;
  logic              port_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              busy_q;
  logic [DEPTH-1:0]  mem_set_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;
`ifdef IAS_MEM_CTRL_VERIFY_EN
  logic              err_q;
`endif

  logic [1:0]        gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] row_rd;
  logic [DEPTH-1:0]  set_dec;

  ias_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({bus.req1, bus.req0}),
    .en_i  (state_q == S_IDLE),
    .gnt_o (gnt)
  );

  assign sel_we    = gnt[1] ? bus.we1    : bus.we0;
  assign sel_addr  = gnt[1] ? bus.addr1  : bus.addr0;
  assign sel_wdata = gnt[1] ? bus.wdata1 : bus.wdata0;
  assign row_rd    = mem_rdata_i[addr_q*DATA_W +: DATA_W];
  assign set_dec   = DEPTH'(1) << addr_q;

  // Access sequencer; every output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      port_q      <= 1'b0;
      addr_q      <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      mem_set_q   <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef IAS_MEM_CTRL_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      mem_set_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt != 2'b00) begin
            port_q <= gnt[1];
            addr_q <= sel_addr;
            busy_q <= 1'b1;
            if (sel_we) begin
              mem_wdata_q <= sel_wdata;
              state_q     <= S_SETUP;
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_SETUP: begin
          mem_set_q <= set_dec;
          state_q   <= S_STROBE;
        end
        S_STROBE: state_q <= S_HOLD;
`ifdef IAS_MEM_CTRL_VERIFY_EN
        // Row is stable by HOLD, so err is already visible in VERIFY.
        S_HOLD: begin
          if (row_rd != mem_wdata_q) err_q <= 1'b1;
          state_q <= S_VERIFY;
        end
        S_VERIFY: begin
          ack0_q  <= !port_q;
          ack1_q  <= port_q;
          state_q <= S_DONE;
        end
`else
        S_HOLD: begin
          ack0_q  <= !port_q;
          ack1_q  <= port_q;
          state_q <= S_DONE;
        end
`endif
        S_READ: begin
          rdata_q <= row_rd;
          ack0_q  <= !port_q;
          ack1_q  <= port_q;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = busy_q;
  assign mem_set_o   = mem_set_q;
  assign mem_wdata_o = mem_wdata_q;
`ifdef IAS_MEM_CTRL_VERIFY_EN
  assign err_o       = err_q;
`endif
endmodule
